seq_serializer: RTL and testbench
=================================

// Module: seq_serializer
// PURPOSE
//   Parallel-to-serial bit-stream source feeding the sequence detector's sequence_in.
//   Accepts words of 1..WIDTH bits over a valid/ready handshake and shifts them out MSB-first, one bit per enabled clock.
//   Double-buffered (shift register + one pending word): consecutive words stream with no idle gap.
//   Marks each valid bit and pulses done at each word end.
// PARAMETERS
//   WIDTH  16  maximum word length in bits
//   LEN_W  5   width of len_in; must hold the value WIDTH
// PORTS
//   clock         in   1      single clock, all logic on rising edge
//   reset         in   1      synchronous, active-high
//   data_in       in   WIDTH  word; active field is data_in[len-1:0]
//   len_in        in   LEN_W  bits to send; 0 or >WIDTH treated as WIDTH
//   load_valid    in   1      producer offers data_in/len_in
//   load_ready    out  1      block can accept a word this cycle
//   shift_en      in   1      advance enable; 0 stalls the stream
//   sequence_out  out  1      serial bit to detector sequence_in
//   bit_valid     out  1      sequence_out carries a word bit
//   busy          out  1      shift register or pending slot occupied
//   done          out  1      one-cycle pulse after a word's last bit is consumed
// BEHAVIOUR
//   Reset is synchronous and active-high; it is sampled only on the rising clock edge.
//   Reset: state IDLE; both slots empty; sequence_out=0, bit_valid=0, busy=0, done=0.
//   load_ready = !reset && !pend_full; it is 1 in the first cycle after reset deasserts.
//   Acceptance: load_valid && load_ready at a rising edge; the word and its length are captured then.
//   States:
//     IDLE: no word shifting; sequence_out=0, bit_valid=0.
//     SHIFT: a word occupies the shift register.
//   IDLE + acceptance -> SHIFT.
//     Next cycle: sequence_out=data_in[len-1], bit_valid=1 (latency 1 clock).
//   SHIFT + acceptance: the word goes to the pending slot; load_ready falls the next cycle.
//   In SHIFT, each edge with shift_en=1 consumes the current bit.
//     Bits are sent in order len-1 down to 0.
//     The bit counter decrements; sequence_out shows the next bit.
//   In SHIFT, shift_en=0 holds sequence_out, the bit counter and bit_valid unchanged.
//     Acceptance into the pending slot is still allowed.
//   Last bit consumed:
//     Pending full: the pending word moves to the shift register. Its MSB appears the next cycle with no gap. The pending slot empties.
//     Pending empty, acceptance in the same cycle: the new word loads straight into the shift register. No gap.
//     Pending empty, no acceptance: go to IDLE. sequence_out=0 and bit_valid=0 the next cycle.
//     In all three cases, done=1 for exactly one cycle (the cycle after consumption).
//   len_in is clamped at acceptance.
//     Valid range 1..WIDTH; 0 or >WIDTH -> WIDTH.
//     The counter is LEN_W bits wide and never wraps below 0.
//   busy = state==SHIFT || pend_full.
//   Data bits above len-1 are ignored.
//   Reset mid-word:
//     Both words are discarded; no done pulse.
//     Outputs take reset values on the next edge.
//   sequence_out, bit_valid and done are registered; no combinational path from inputs.
// TESTING
//   1. Load 0x01DB, len 9, shift_en=1 -> sequence_out 1,1,1,0,1,1,0,1,1 on cycles 1..9 after accept, bit_valid=1. Cycle 10: done=1, bit_valid=0, sequence_out=0.
//   2. Load 0x01DB len 9, then 0x02DB len 10 while the first word shifts -> 19 contiguous bits 111011011 1011011011. load_ready=0 while pending is full. Two done pulses.
//   3. Word 0x01DB, shift_en=0 for 3 cycles after the 4th bit -> 4th bit (0) held 3 extra cycles. Total valid span 12 cycles. Bit order unchanged.
//   4. len_in=0, data_in=0xA5C3 -> 16 bits 1010010111000011, then done.
//   5. reset=1 on the 5th bit of a 9-bit word with a word pending -> next cycle all outputs 0, no done. load_ready=1 once reset is low.
//   6. Pending empty, new word accepted on the edge consuming the last bit -> next word's MSB on the following cycle. bit_valid never drops.

Source files
------------

// File: rtl/seq_serializer.sv
// Parallel-to-serial source for the sequence detector: accepts 1..WIDTH-bit words over
// valid/ready and streams them MSB-first, with one pending slot so back-to-back words leave no gap.
module seq_serializer #(
  parameter int WIDTH = 16,
  parameter int LEN_W = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_in,
  input  logic [LEN_W-1:0] len_in,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic             shift_en,
  output logic             sequence_out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done
);

  localparam logic [0:0]       ST_IDLE  = 1'b0;
  localparam logic [0:0]       ST_SHIFT = 1'b1;
  localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(WIDTH);
  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1'b1);
  localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};

  // Lengths of zero or beyond WIDTH mean a full-width word.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] l);
    logic [LEN_W-1:0] r;
    if ((l == LEN_ZERO) || (l > LEN_MAX)) begin
      r = LEN_MAX;
    end else begin
      r = l;
    end
    return r;
  endfunction

  // Left-justify so bit len-1 sits at the MSB; unused upper bits fall off the top.
  function automatic logic [WIDTH-1:0] align_word(input logic [WIDTH-1:0] d,
                                                  input logic [LEN_W-1:0] l);
    return d << (LEN_MAX - l);
  endfunction

  logic [0:0]       state_r,     state_s;
  logic [WIDTH-1:0] shreg_r,     shreg_s;
  logic [LEN_W-1:0] cnt_r,       cnt_s;
  logic [WIDTH-1:0] pend_word_r, pend_word_s;
  logic [LEN_W-1:0] pend_len_r,  pend_len_s;
  logic             pend_full_r, pend_full_s;
  logic             seq_out_r,   bit_valid_r, busy_r, done_r;

  logic             accept_s, consume_s, last_s;
  logic [LEN_W-1:0] in_len_s;
  logic [WIDTH-1:0] in_word_s;

  assign load_ready   = !reset && !pend_full_r;
  assign sequence_out = seq_out_r;
  assign bit_valid    = bit_valid_r;
  assign busy         = busy_r;
  assign done         = done_r;

  // Next-state logic for the shift register, bit counter and pending slot.
  always_comb begin
    accept_s    = load_valid && load_ready;
    in_len_s    = clamp_len(len_in);
    in_word_s   = align_word(data_in, in_len_s);
    consume_s   = (state_r == ST_SHIFT) && shift_en;
    last_s      = consume_s && (cnt_r <= LEN_ONE);
    state_s     = state_r;
    shreg_s     = shreg_r;
    cnt_s       = cnt_r;
    pend_word_s = pend_word_r;
    pend_len_s  = pend_len_r;
    pend_full_s = pend_full_r;

    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_s = ST_SHIFT;
          shreg_s = in_word_s;
          cnt_s   = in_len_s;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        if (last_s) begin
          // Word boundary: refill from the pending slot first, else take a word offered now.
          if (pend_full_r) begin
            shreg_s     = pend_word_r;
            cnt_s       = pend_len_r;
            pend_full_s = 1'b0;
          end else if (accept_s) begin
            shreg_s = in_word_s;
            cnt_s   = in_len_s;
          end else begin
            state_s = ST_IDLE;
            shreg_s = {WIDTH{1'b0}};
            cnt_s   = LEN_ZERO;
          end
        end else begin
          if (consume_s) begin
            shreg_s = shreg_r << 1;
            cnt_s   = cnt_r - LEN_ONE;
          end else begin
            shreg_s = shreg_r;
            cnt_s   = cnt_r;
          end
          if (accept_s) begin
            pend_word_s = in_word_s;
            pend_len_s  = in_len_s;
            pend_full_s = 1'b1;
          end else begin
            pend_full_s = pend_full_r;
          end
        end
      end
      default: begin
        state_s     = ST_IDLE;
        shreg_s     = {WIDTH{1'b0}};
        cnt_s       = LEN_ZERO;
        pend_full_s = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      shreg_r     <= {WIDTH{1'b0}};
      cnt_r       <= LEN_ZERO;
      pend_word_r <= {WIDTH{1'b0}};
      pend_len_r  <= LEN_ZERO;
      pend_full_r <= 1'b0;
      seq_out_r   <= 1'b0;
      bit_valid_r <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
    end else begin
      state_r     <= state_s;
      shreg_r     <= shreg_s;
      cnt_r       <= cnt_s;
      pend_word_r <= pend_word_s;
      pend_len_r  <= pend_len_s;
      pend_full_r <= pend_full_s;
      seq_out_r   <= (state_s == ST_SHIFT) ? shreg_s[WIDTH-1] : 1'b0;
      bit_valid_r <= (state_s == ST_SHIFT);
      busy_r      <= (state_s == ST_SHIFT) || pend_full_s;
      done_r      <= last_s;
    end
  end

endmodule

// File: tb/tb_seq_serializer.sv
// Scoreboard bench for seq_serializer: stimulus queues expected bits, a negedge monitor
// pops and compares them and tracks done pulses and their timing.
module tb_seq_serializer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] data_in = 16'h0000;
  logic [4:0]  len_in = 5'd0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic        shift_en = 1'b0;
  logic        sequence_out, bit_valid, busy, done;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_done_cyc = 0;
  logic        exp_done = 1'b0;
  logic [1:0]  sb[$];  // {last, bit}

  seq_serializer #(.WIDTH(16), .LEN_W(5)) dut (
    .clock(clock), .reset(reset), .data_in(data_in), .len_in(len_in),
    .load_valid(load_valid), .load_ready(load_ready), .shift_en(shift_en),
    .sequence_out(sequence_out), .bit_valid(bit_valid), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  // Offer one word, queue its expected bits, return the monitor cycle count at acceptance.
  task automatic send_word(input logic [15:0] d, input logic [4:0] l, output int c0);
    int n;
    data_in = d;
    len_in = l;
    load_valid = 1'b1;
    for (int k = 0; k < 50; k++) begin
      if (load_ready) break;
      @(posedge clock); #1;
    end
    check("load_ready_wait", load_ready, 1);
    n = (l == 5'd0 || l > 5'd16) ? 16 : int'(l);
    for (int i = n - 1; i >= 0; i--) sb.push_back({i == 0, d[i]});
    @(posedge clock); #1;
    load_valid = 1'b0;
    c0 = cyc;
  endtask

  task automatic drain(input string nm, input int c0, input int nbits);
    for (int k = 0; k < 200 && sb.size() != 0; k++) @(posedge clock);
    check({nm, "_drain"}, sb.size(), 0);
    repeat (2) @(posedge clock);
    #1;
    check({nm, "_done_cycle"}, last_done_cyc, c0 + nbits + 1);
    check({nm, "_idle_valid"}, bit_valid, 0);
    check({nm, "_idle_seq"}, sequence_out, 0);
    check({nm, "_idle_busy"}, busy, 0);
  endtask

  // Monitor: compare the displayed bit, pop it on consumption, expect done one cycle later.
  initial begin
    logic [1:0] e;
    forever begin
      @(negedge clock);
      cyc++;
      check("done", done, exp_done);
      if (done === 1'b1) last_done_cyc = cyc;
      exp_done = 1'b0;
      if (!reset && bit_valid) begin
        if (sb.size() == 0) begin
          check("unexpected_bit", bit_valid, 0);
        end else begin
          e = sb[0];
          check("seq_bit", sequence_out, e[0]);
          if (shift_en) begin
            void'(sb.pop_front());
            exp_done = e[1];
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0, cx;
    repeat (3) @(posedge clock);
    #1;
    check("rst_seq", sequence_out, 0);
    check("rst_valid", bit_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready", load_ready, 0);
    reset = 1'b0;
    #1;
    check("ready_after_rst", load_ready, 1);
    shift_en = 1'b1;

    // 1: single 9-bit word 111011011
    send_word(16'h01DB, 5'd9, c0);
    check("t1_busy", busy, 1);
    drain("t1", c0, 9);

    // 2: second word queued while the first streams -> 19 contiguous bits
    send_word(16'h01DB, 5'd9, c0);
    send_word(16'h02DB, 5'd10, cx);
    check("t2_ready_low", load_ready, 0);
    check("t2_busy", busy, 1);
    drain("t2", c0, 19);

    // 3: stall 3 cycles while the 4th bit is shown
    send_word(16'h01DB, 5'd9, c0);
    repeat (3) @(posedge clock);
    #1;
    shift_en = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    shift_en = 1'b1;
    drain("t3", c0, 12);

    // 4: len 0 means full width
    send_word(16'hA5C3, 5'd0, c0);
    drain("t4", c0, 16);

    // 6: new word accepted on the edge that consumes the last bit
    send_word(16'h0005, 5'd3, c0);
    repeat (2) @(posedge clock);
    #1;
    send_word(16'h0006, 5'd4, cx);
    drain("t6", c0, 7);

    // 5: reset on the 5th bit with a word pending
    send_word(16'h01DB, 5'd9, c0);
    send_word(16'h02DB, 5'd10, cx);
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b1;
    @(posedge clock);
    #1;
    sb.delete();
    check("t5_seq", sequence_out, 0);
    check("t5_valid", bit_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_done", done, 0);
    check("t5_ready_in_rst", load_ready, 0);
    reset = 1'b0;
    #1;
    check("t5_ready_after", load_ready, 1);
    repeat (4) @(posedge clock);
    #1;
    check("t5_still_idle", bit_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
